// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle for unified_mem_arbiter: fetch port, data port and the shared memory port.
// slave = the arbiter's view, master = the surrounding pipeline and memory.
interface unified_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_gnt_o;
  logic                  if_rvalid_o;
  logic [DATA_WIDTH-1:0] if_rdata_o;
  logic                  flush_i;
  logic                  d_req_i;
  logic                  d_we_i;
  logic [BE_WIDTH-1:0]   d_be_i;
  logic [ADDR_WIDTH-1:0] d_addr_i;
  logic [DATA_WIDTH-1:0] d_wdata_i;
  logic                  d_gnt_o;
  logic                  d_rvalid_o;
  logic [DATA_WIDTH-1:0] d_rdata_o;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [BE_WIDTH-1:0]   mem_be_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  err_o;

  modport slave (
    input  if_req_i, if_addr_i, flush_i, d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, err_o
  );

  modport master (
    output if_req_i, if_addr_i, flush_i, d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, err_o
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between the fetch and data ports, one transaction in flight,
// data-first priority bounded by a fetch starvation counter, flush kills pending fetch data.
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH         = 32,
  parameter int DATA_WIDTH         = 32,
  parameter int FETCH_STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  unified_mem_arbiter_if.slave bus
);
  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(FETCH_STARVE_LIMIT + 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_FETCH = 2'd1, OWN_DATA = 2'd2} owner_t;

  state_t                state_r, state_s;
  owner_t                owner_r;
  logic [CNT_WIDTH-1:0]  starve_cnt_r;
  logic                  killed_r, err_r, mem_req_r, mem_we_r;
  logic [BE_WIDTH-1:0]   mem_be_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic                  starve_hit_s, proto_err_s, fetch_flush_s;
  logic                  if_gnt_s, d_gnt_s, if_rvalid_s, d_rvalid_s;
  logic                  if_rvalid_out_s, d_rvalid_out_s;

  assign starve_hit_s  = (starve_cnt_r == CNT_WIDTH'(FETCH_STARVE_LIMIT));
  assign proto_err_s   = (bus.mem_rvalid_i && (state_r != ST_WAIT)) ||
                         (bus.mem_gnt_i && (state_r != ST_REQ));
  assign fetch_flush_s = bus.flush_i && (owner_r == OWN_FETCH);

  // Next-state, grant arbitration and response routing.
  always_comb begin
    state_s     = state_r;
    if_gnt_s    = 1'b0;
    d_gnt_s     = 1'b0;
    if_rvalid_s = 1'b0;
    d_rvalid_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.d_req_i && !(bus.if_req_i && starve_hit_s)) begin
          d_gnt_s = 1'b1;
          state_s = ST_REQ;
        end else if (bus.if_req_i) begin
          if_gnt_s = 1'b1;
          state_s  = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.mem_gnt_i) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (bus.mem_rvalid_i) begin
          state_s = ST_IDLE;
          case (owner_r)
            OWN_DATA:  d_rvalid_s  = 1'b1;
            OWN_FETCH: if_rvalid_s = !killed_r && !bus.flush_i;
            default:   d_rvalid_s  = 1'b0;
          endcase
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Reset forces the combinational pulses low so nothing leaks out during the reset cycle.
  assign bus.if_gnt_o    = if_gnt_s & ~rst;
  assign bus.d_gnt_o     = d_gnt_s & ~rst;
  assign if_rvalid_out_s = if_rvalid_s & ~rst;
  assign d_rvalid_out_s  = d_rvalid_s & ~rst;
  assign bus.if_rvalid_o = if_rvalid_out_s;
  assign bus.d_rvalid_o  = d_rvalid_out_s;
  assign bus.if_rdata_o  = if_rvalid_out_s ? bus.mem_rdata_i : {DATA_WIDTH{1'b0}};
  assign bus.d_rdata_o   = d_rvalid_out_s ? bus.mem_rdata_i : {DATA_WIDTH{1'b0}};
  assign bus.mem_req_o   = mem_req_r;
  assign bus.mem_we_o    = mem_we_r;
  assign bus.mem_be_o    = mem_be_r;
  assign bus.mem_addr_o  = mem_addr_r;
  assign bus.mem_wdata_o = mem_wdata_r;
  assign bus.err_o       = err_r;

  // State, captured request fields, owner, starvation counter, kill flag and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      owner_r      <= OWN_NONE;
      starve_cnt_r <= {CNT_WIDTH{1'b0}};
      killed_r     <= 1'b0;
      err_r        <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_be_r     <= {BE_WIDTH{1'b0}};
      mem_addr_r   <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      err_r   <= err_r | proto_err_s;
      case (state_r)
        ST_IDLE: begin
          mem_req_r <= d_gnt_s | if_gnt_s;
          killed_r  <= 1'b0;
          if (d_gnt_s) begin
            owner_r     <= OWN_DATA;
            mem_we_r    <= bus.d_we_i;
            mem_be_r    <= bus.d_be_i;
            mem_addr_r  <= bus.d_addr_i;
            mem_wdata_r <= bus.d_wdata_i;
          end else if (if_gnt_s) begin
            owner_r     <= OWN_FETCH;
            mem_we_r    <= 1'b0;
            mem_be_r    <= {BE_WIDTH{1'b1}};
            mem_addr_r  <= bus.if_addr_i;
            mem_wdata_r <= {DATA_WIDTH{1'b0}};
          end else begin
            owner_r <= OWN_NONE;
          end
          // Only data grants that overtake a waiting fetch count toward starvation.
          if (!bus.if_req_i || if_gnt_s) begin
            starve_cnt_r <= {CNT_WIDTH{1'b0}};
          end else if (d_gnt_s && !starve_hit_s) begin
            starve_cnt_r <= starve_cnt_r + CNT_WIDTH'(1);
          end else begin
            starve_cnt_r <= starve_cnt_r;
          end
        end
        ST_REQ: begin
          if (bus.mem_gnt_i) begin
            mem_req_r <= 1'b0;
          end
          if (fetch_flush_s) begin
            killed_r <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.mem_rvalid_i) begin
            owner_r  <= OWN_NONE;
            killed_r <= 1'b0;
          end else if (fetch_flush_s) begin
            killed_r <= 1'b1;
          end
        end
        default: owner_r <= OWN_NONE;
      endcase
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_unified_mem_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  unified_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FETCH_STARVE_LIMIT(LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder state
  logic [31:0] mem_arr [0:255];
  int          gnt_delay     = 0;
  int          wait_cnt      = 0;
  bit          resp_due      = 1'b0;
  bit          inject_rvalid = 1'b0;
  logic        t_we;
  logic [3:0]  t_be;
  logic [31:0] t_addr, t_wdata;

  // Advance one clock; memory side is driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    bus.mem_rvalid_i = inject_rvalid;
    bus.mem_rdata_i  = 32'd0;
    inject_rvalid    = 1'b0;
    if (resp_due) begin
      bus.mem_rvalid_i = 1'b1;
      if (t_we) begin
        for (int b = 0; b < 4; b++)
          if (t_be[b]) mem_arr[t_addr[9:2]][8*b +: 8] = t_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata_i = mem_arr[t_addr[9:2]];
      end
      resp_due = 1'b0;
    end
    bus.mem_gnt_i = 1'b0;
    if (bus.mem_req_o === 1'b1) begin
      if (wait_cnt >= gnt_delay) begin
        bus.mem_gnt_i = 1'b1;
        t_we     = bus.mem_we_o;
        t_be     = bus.mem_be_o;
        t_addr   = bus.mem_addr_o;
        t_wdata  = bus.mem_wdata_o;
        resp_due = 1'b1;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  endtask

  // Transaction-level model: one optional in-flight transaction plus a streak counter.
  bit          m_busy = 1'b0, m_is_data = 1'b0, m_sent = 1'b0, m_dead = 1'b0, m_err = 1'b0;
  int          m_streak = 0;
  logic [31:0] m_addr = 32'd0, m_wdata = 32'd0;
  logic [3:0]  m_be = 4'd0;
  logic        m_we = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        bit dg, fg, rsp, dr, fr, mreq;
        dg   = !rst && !m_busy && bus.d_req_i && !(bus.if_req_i && (m_streak >= LIMIT));
        fg   = !rst && !m_busy && bus.if_req_i && !dg;
        rsp  = !rst && m_busy && m_sent && bus.mem_rvalid_i;
        dr   = rsp && m_is_data;
        fr   = rsp && !m_is_data && !m_dead && !bus.flush_i;
        mreq = m_busy && !m_sent;
        check("d_gnt", {31'd0, bus.d_gnt_o}, {31'd0, dg});
        check("if_gnt", {31'd0, bus.if_gnt_o}, {31'd0, fg});
        check("d_rvalid", {31'd0, bus.d_rvalid_o}, {31'd0, dr});
        check("if_rvalid", {31'd0, bus.if_rvalid_o}, {31'd0, fr});
        check("mem_req", {31'd0, bus.mem_req_o}, {31'd0, mreq});
        check("err", {31'd0, bus.err_o}, {31'd0, m_err});
        if (dr) check("d_rdata", bus.d_rdata_o, bus.mem_rdata_i);
        if (fr) check("if_rdata", bus.if_rdata_o, bus.mem_rdata_i);
        if (mreq) begin
          check("mem_addr", bus.mem_addr_o, m_addr);
          check("mem_we", {31'd0, bus.mem_we_o}, {31'd0, m_we});
          check("mem_be", {28'd0, bus.mem_be_o}, {28'd0, m_be});
          check("mem_wdata", bus.mem_wdata_o, m_wdata);
        end
        if (rst) begin
          m_busy = 1'b0; m_sent = 1'b0; m_dead = 1'b0; m_err = 1'b0; m_streak = 0;
        end else begin
          m_err = m_err | (bus.mem_rvalid_i && !(m_busy && m_sent)) | (bus.mem_gnt_i && !mreq);
          if (!m_busy) begin
            if (dg || fg) begin
              m_busy = 1'b1; m_sent = 1'b0; m_dead = 1'b0; m_is_data = dg;
              m_addr  = dg ? bus.d_addr_i : bus.if_addr_i;
              m_we    = dg ? bus.d_we_i : 1'b0;
              m_be    = dg ? bus.d_be_i : 4'hF;
              m_wdata = dg ? bus.d_wdata_i : 32'd0;
            end
            if (!bus.if_req_i || fg) m_streak = 0;
            else if (dg && m_streak < LIMIT) m_streak++;
          end else if (!m_sent) begin
            if (bus.mem_gnt_i) m_sent = 1'b1;
            if (!m_is_data && bus.flush_i) m_dead = 1'b1;
          end else begin
            if (bus.mem_rvalid_i) m_busy = 1'b0;
            else if (!m_is_data && bus.flush_i) m_dead = 1'b1;
          end
        end
      end
    end
  end

  task automatic d_xfer(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata);
    int n;
    bus.d_req_i = 1'b1; bus.d_we_i = we; bus.d_be_i = be;
    bus.d_addr_i = addr; bus.d_wdata_i = wdata;
    n = 0;
    #1;
    while (!bus.d_gnt_o && n < 30) begin step(); n++; #1; end
    check("d_gnt_seen", {31'd0, bus.d_gnt_o}, 32'd1);
    step();
    bus.d_req_i = 1'b0;
    n = 0;
    #1;
    while (!bus.d_rvalid_o && n < 30) begin step(); n++; #1; end
    check("d_rvalid_seen", {31'd0, bus.d_rvalid_o}, 32'd1);
    rdata = bus.d_rdata_o;
    step();
  endtask

  task automatic f_xfer(input logic [31:0] addr, input bit flush_at_req, output logic [31:0] rdata);
    int n;
    bus.if_req_i = 1'b1; bus.if_addr_i = addr; bus.flush_i = flush_at_req;
    n = 0;
    #1;
    while (!bus.if_gnt_o && n < 30) begin step(); n++; #1; end
    check("if_gnt_seen", {31'd0, bus.if_gnt_o}, 32'd1);
    step();
    bus.if_req_i = 1'b0; bus.flush_i = 1'b0;
    n = 0;
    #1;
    while (!bus.if_rvalid_o && n < 30) begin step(); n++; #1; end
    check("if_rvalid_seen", {31'd0, bus.if_rvalid_o}, 32'd1);
    rdata = bus.if_rdata_o;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [5:0]  pat;
    int          n_g, cyc;
    bit          fetch_taken;
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'd0;
    mem_arr[8'h40] = 32'hDEAD_BEEF;   // 0x100
    mem_arr[8'h41] = 32'hAAAA_AAAA;   // 0x104
    mem_arr[8'h80] = 32'hCAFE_0001;   // 0x200
    mem_arr[8'h81] = 32'hCAFE_0002;   // 0x204
    mem_arr[8'h82] = 32'hCAFE_0003;   // 0x208
    bus.if_req_i = 1'b0; bus.if_addr_i = 32'd0; bus.flush_i = 1'b0;
    bus.d_req_i = 1'b0; bus.d_we_i = 1'b0; bus.d_be_i = 4'd0;
    bus.d_addr_i = 32'd0; bus.d_wdata_i = 32'd0;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = 32'd0;

    // Reset state
    step();
    chk_en = 1'b1;
    step();
    #1;
    check("rst_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    check("rst_mem_addr", bus.mem_addr_o, 32'd0);
    check("rst_err", {31'd0, bus.err_o}, 32'd0);
    rst = 1'b0;

    // 1: single zero-wait load
    step();
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_be_i = 4'hF; bus.d_addr_i = 32'h100;
    #1;
    check("t1_d_gnt_c0", {31'd0, bus.d_gnt_o}, 32'd1);
    step(); bus.d_req_i = 1'b0; #1;
    check("t1_mem_req_c1", {31'd0, bus.mem_req_o}, 32'd1);
    check("t1_mem_addr_c1", bus.mem_addr_o, 32'h100);
    check("t1_mem_we_c1", {31'd0, bus.mem_we_o}, 32'd0);
    step(); #1;
    check("t1_d_rvalid_c2", {31'd0, bus.d_rvalid_o}, 32'd1);
    check("t1_d_rdata_c2", bus.d_rdata_o, 32'hDEAD_BEEF);
    step();

    // 2: simultaneous requests, data store wins, fetch follows
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_be_i = 4'h3;
    bus.d_addr_i = 32'h104; bus.d_wdata_i = 32'h1234_5678;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h200;
    #1;
    check("t2_d_gnt", {31'd0, bus.d_gnt_o}, 32'd1);
    check("t2_if_gnt_lost", {31'd0, bus.if_gnt_o}, 32'd0);
    step(); bus.d_req_i = 1'b0; #1;
    check("t2_mem_we", {31'd0, bus.mem_we_o}, 32'd1);
    check("t2_mem_be", {28'd0, bus.mem_be_o}, 32'h3);
    step(); #1;
    check("t2_store_ack", {31'd0, bus.d_rvalid_o}, 32'd1);
    step(); #1;
    check("t2_if_gnt", {31'd0, bus.if_gnt_o}, 32'd1);
    step(); bus.if_req_i = 1'b0; #1;
    check("t2_fetch_be", {28'd0, bus.mem_be_o}, 32'hF);
    step(); #1;
    check("t2_if_rdata", bus.if_rdata_o, 32'hCAFE_0001);
    step();
    d_xfer(1'b0, 4'hF, 32'h104, 32'd0, rd);
    check("t2_store_merge", rd, 32'hAAAA_5678);

    // 3: starvation bound, LIMIT data grants then fetch then data
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h208;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_be_i = 4'hF; bus.d_addr_i = 32'h100;
    pat = 6'd0; n_g = 0; cyc = 0; fetch_taken = 1'b0;
    while (n_g < 6 && cyc < 80) begin
      #1;
      if (bus.d_gnt_o) begin
        n_g++;
      end else if (bus.if_gnt_o) begin
        pat[n_g] = 1'b1; n_g++; fetch_taken = 1'b1;
      end
      step(); cyc++;
      if (fetch_taken) begin bus.if_req_i = 1'b0; fetch_taken = 1'b0; end
      if (n_g == 6) bus.d_req_i = 1'b0;
    end
    bus.d_req_i = 1'b0;
    check("t3_grant_count", n_g, 32'd6);
    check("t3_grant_pattern", {26'd0, pat}, 32'b010000);
    step(); step(); step();

    // 4: delayed memory grant, flush while in REQ kills the fetch response
    gnt_delay = 3;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h200;
    #1;
    check("t4_if_gnt", {31'd0, bus.if_gnt_o}, 32'd1);
    step(); bus.if_req_i = 1'b0; #1;
    check("t4_mem_req_c1", {31'd0, bus.mem_req_o}, 32'd1);
    step(); bus.flush_i = 1'b1; #1;
    check("t4_mem_req_c2", {31'd0, bus.mem_req_o}, 32'd1);
    step(); bus.flush_i = 1'b0; #1;
    check("t4_mem_req_c3", {31'd0, bus.mem_req_o}, 32'd1);
    step(); #1;
    check("t4_mem_req_c4", {31'd0, bus.mem_req_o}, 32'd1);
    check("t4_mem_gnt_c4", {31'd0, bus.mem_gnt_i}, 32'd1);
    step(); #1;
    check("t4_killed_rvalid", {31'd0, bus.if_rvalid_o}, 32'd0);
    step();
    gnt_delay = 0;
    f_xfer(32'h204, 1'b0, rd);
    check("t4_next_fetch", rd, 32'hCAFE_0002);
    f_xfer(32'h208, 1'b1, rd);
    check("t4_idle_flush_fetch", rd, 32'hCAFE_0003);
    bus.flush_i = 1'b1;
    d_xfer(1'b0, 4'hF, 32'h100, 32'd0, rd);
    bus.flush_i = 1'b0;
    check("t4_flush_data_load", rd, 32'hDEAD_BEEF);

    // 5: stray response in IDLE
    #1;
    check("t5_err_before", {31'd0, bus.err_o}, 32'd0);
    inject_rvalid = 1'b1;
    step(); #1;
    check("t5_no_d_rvalid", {31'd0, bus.d_rvalid_o}, 32'd0);
    check("t5_no_if_rvalid", {31'd0, bus.if_rvalid_o}, 32'd0);
    step(); #1;
    check("t5_err_set", {31'd0, bus.err_o}, 32'd1);
    d_xfer(1'b0, 4'hF, 32'h100, 32'd0, rd);
    check("t5_later_load", rd, 32'hDEAD_BEEF);
    #1;
    check("t5_err_sticky", {31'd0, bus.err_o}, 32'd1);

    // 6: reset while waiting for the response
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_be_i = 4'hF; bus.d_addr_i = 32'h100;
    #1;
    check("t6_d_gnt", {31'd0, bus.d_gnt_o}, 32'd1);
    step(); bus.d_req_i = 1'b0;
    step();
    rst = 1'b1; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = 32'd0; resp_due = 1'b0;
    #1;
    check("t6_no_rvalid_in_rst", {31'd0, bus.d_rvalid_o}, 32'd0);
    step(); #1;
    check("t6_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    check("t6_mem_addr", bus.mem_addr_o, 32'd0);
    check("t6_mem_be", {28'd0, bus.mem_be_o}, 32'd0);
    check("t6_err_cleared", {31'd0, bus.err_o}, 32'd0);
    rst = 1'b0;
    step();
    d_xfer(1'b0, 4'hF, 32'h104, 32'd0, rd);
    check("t6_after_reset_load", rd, 32'hAAAA_5678);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
